// File: rtl/dma_channel_arbiter_if.sv
// Request/acknowledge bundle between the DMA arbiter and the controller logic around it.
// The slave modport is the arbiter's view; master drives requests, command bits and HLDA.
interface dma_channel_arbiter_if #(
  parameter int NUM_CH = 4
);
  localparam int CH_W = $clog2(NUM_CH);

  logic [NUM_CH-1:0] dreq;
  logic [NUM_CH-1:0] sw_req;
  logic [NUM_CH-1:0] mask;
  logic              cmd_disable;
  logic              cmd_rotating;
  logic              cmd_dreq_low;
  logic              cmd_dack_low;
  logic              hlda;
  logic              svc_done;
  logic              hrq;
  logic [NUM_CH-1:0] dack;
  logic              grant_valid;
  logic [CH_W-1:0]   grant_ch;

  modport master (
    output dreq, sw_req, mask, cmd_disable, cmd_rotating, cmd_dreq_low, cmd_dack_low,
    output hlda, svc_done,
    input  hrq, dack, grant_valid, grant_ch
  );

  modport slave (
    input  dreq, sw_req, mask, cmd_disable, cmd_rotating, cmd_dreq_low, cmd_dack_low,
    input  hlda, svc_done,
    output hrq, dack, grant_valid, grant_ch
  );
endinterface

// File: rtl/dma_channel_arbiter.sv
// 8237-style DMA request arbiter: HRQ/HLDA handshake, fixed or rotating priority, one-hot DACK.
// All outputs registered; HRQ follows a request by one cycle, grant follows HLDA by one cycle.
module dma_channel_arbiter #(
  parameter int NUM_CH = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  dma_channel_arbiter_if.slave bus
);
  localparam int CH_W = $clog2(NUM_CH);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2,
    RELEASE = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic              hrq_q, hrq_d;
  logic              gv_q, gv_d;
  logic [CH_W-1:0]   grant_q, grant_d;
  logic [CH_W-1:0]   top_q, top_d;
  logic [NUM_CH-1:0] dack_q, dack_d;

  logic [NUM_CH-1:0] eff_req;
  logic              win_found;
  logic [CH_W-1:0]   win_ch;
  logic [CH_W-1:0]   base;
  logic [CH_W:0]     idx;
  logic [NUM_CH-1:0] ack_onehot;

  assign eff_req = ((bus.dreq ^ {NUM_CH{bus.cmd_dreq_low}}) & ~bus.mask) | bus.sw_req;

  // Walk from lowest to highest priority so the last hit is the winner.
  always_comb begin
    win_found = 1'b0;
    win_ch    = '0;
    idx       = '0;
    base      = bus.cmd_rotating ? top_q : '0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      idx = {1'b0, base} + (CH_W + 1)'(k);
      if (idx >= (CH_W + 1)'(NUM_CH)) idx = idx - (CH_W + 1)'(NUM_CH);
      if (eff_req[idx[CH_W-1:0]]) begin
        win_found = 1'b1;
        win_ch    = idx[CH_W-1:0];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    hrq_d   = hrq_q;
    gv_d    = gv_q;
    grant_d = grant_q;
    top_d   = top_q;
    case (state_q)
      IDLE: begin
        hrq_d = 1'b0;
        gv_d  = 1'b0;
        if (|eff_req && !bus.cmd_disable) begin
          state_d = REQ;
          hrq_d   = 1'b1;
        end
      end
      REQ: begin
        hrq_d = 1'b1;
        if (bus.hlda) begin
          if (win_found) begin
            state_d = SERVICE;
            gv_d    = 1'b1;
            grant_d = win_ch;
          end else begin
            state_d = RELEASE;
            hrq_d   = 1'b0;
          end
        end
      end
      SERVICE: begin
        // Completion wins over a simultaneous HLDA drop, so the pointer still rotates.
        if (bus.svc_done) begin
          state_d = RELEASE;
          hrq_d   = 1'b0;
          gv_d    = 1'b0;
          if (bus.cmd_rotating)
            top_d = (grant_q == CH_W'(NUM_CH - 1)) ? '0 : grant_q + 1'b1;
        end else if (!bus.hlda) begin
          state_d = IDLE;
          hrq_d   = 1'b0;
          gv_d    = 1'b0;
          grant_d = '0;
        end
      end
      RELEASE: begin
        hrq_d = 1'b0;
        gv_d  = 1'b0;
        if (!bus.hlda) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        hrq_d   = 1'b0;
        gv_d    = 1'b0;
      end
    endcase
  end

  assign ack_onehot = gv_d ? (NUM_CH'(1) << grant_d) : '0;
  assign dack_d     = ack_onehot ^ {NUM_CH{bus.cmd_dack_low}};

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      hrq_q   <= 1'b0;
      gv_q    <= 1'b0;
      grant_q <= '0;
      top_q   <= '0;
      dack_q  <= {NUM_CH{bus.cmd_dack_low}};
    end else begin
      state_q <= state_d;
      hrq_q   <= hrq_d;
      gv_q    <= gv_d;
      grant_q <= grant_d;
      top_q   <= top_d;
      dack_q  <= dack_d;
    end
  end

  assign bus.hrq         = hrq_q;
  assign bus.grant_valid = gv_q;
  assign bus.grant_ch    = grant_q;
  assign bus.dack        = dack_q;
endmodule

// File: tb/tb_dma_channel_arbiter.sv
// Bench for dma_channel_arbiter: directed scenarios plus randomized transactions
// against a transaction-level priority model.
module tb_dma_channel_arbiter;
  localparam int N  = 4;
  localparam int CW = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  dma_channel_arbiter_if #(.NUM_CH(N)) bus ();
  dma_channel_arbiter #(.NUM_CH(N)) dut (.clk(clk), .reset(reset), .bus(bus.slave));

  int errors = 0;
  int checks = 0;
  int m_top  = 0;

  function automatic logic [N-1:0] m_eff(input logic [N-1:0] d, input logic [N-1:0] s,
                                         input logic [N-1:0] m, input logic lo);
    return ((d ^ {N{lo}}) & ~m) | s;
  endfunction

  function automatic int m_winner(input logic [N-1:0] eff, input bit rot, input int top);
    int start;
    start = rot ? top : 0;
    for (int k = 0; k < N; k++)
      if (eff[(start + k) % N]) return (start + k) % N;
    return -1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_hrq(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 32; i++) begin
      if (bus.hrq === 1'b1) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic grant_cycle(input int dly, output bit ok, output logic gv,
                             output logic [CW-1:0] ch, output logic [N-1:0] dk);
    gv = 1'b0; ch = '0; dk = '0;
    wait_hrq(ok);
    if (!ok) return;
    repeat (dly) tick();
    bus.hlda = 1'b1;
    tick();
    gv = bus.grant_valid;
    ch = bus.grant_ch;
    dk = bus.dack;
  endtask

  task automatic finish_service(input int hold, output logic gv_pre, output logic [CW-1:0] ch_pre,
                                output logic hrq_post, output logic gv_post,
                                output logic [N-1:0] dk_post);
    repeat (hold) tick();
    gv_pre = bus.grant_valid;
    ch_pre = bus.grant_ch;
    bus.svc_done = 1'b1;
    tick();
    bus.svc_done = 1'b0;
    hrq_post = bus.hrq;
    gv_post  = bus.grant_valid;
    dk_post  = bus.dack;
    bus.mask   = '1;
    bus.sw_req = '0;
    bus.hlda   = 1'b0;
    tick();
    tick();
  endtask

  bit              ok;
  logic            gv, gv_pre, hrq_post, gv_post;
  logic [CW-1:0]   ch, ch_pre;
  logic [N-1:0]    dk, dk_post;

  task automatic test_reset();
    reset = 1'b1;
    bus.cmd_dack_low = 1'b1;
    tick();
    checks++; if (bus.dack !== 4'b1111) begin errors++; $display("FAIL reset_dack_low: got %b want 1111", bus.dack); end
    bus.cmd_dack_low = 1'b0;
    tick();
    checks++; if (bus.hrq !== 1'b0) begin errors++; $display("FAIL reset_hrq: got %b want 0", bus.hrq); end
    checks++; if (bus.grant_valid !== 1'b0) begin errors++; $display("FAIL reset_gv: got %b want 0", bus.grant_valid); end
    checks++; if (bus.grant_ch !== 2'd0) begin errors++; $display("FAIL reset_ch: got %0d want 0", bus.grant_ch); end
    checks++; if (bus.dack !== 4'b0000) begin errors++; $display("FAIL reset_dack: got %b want 0000", bus.dack); end
    reset = 1'b0;
    m_top = 0;
    tick();
  endtask

  task automatic test_fixed();
    bus.cmd_rotating = 1'b0; bus.mask = '0; bus.dreq = 4'b1010;
    tick();
    checks++; if (bus.hrq !== 1'b1) begin errors++; $display("FAIL fixed_hrq_latency: got %b want 1", bus.hrq); end
    repeat (2) tick();
    bus.hlda = 1'b1;
    tick();
    checks++; if (bus.grant_valid !== 1'b1 || bus.grant_ch !== 2'd1) begin errors++; $display("FAIL fixed_grant: got v=%b ch=%0d want v=1 ch=1", bus.grant_valid, bus.grant_ch); end
    checks++; if (bus.dack !== 4'b0010) begin errors++; $display("FAIL fixed_dack: got %b want 0010", bus.dack); end
    finish_service(3, gv_pre, ch_pre, hrq_post, gv_post, dk_post);
    checks++; if (gv_pre !== 1'b1 || ch_pre !== 2'd1) begin errors++; $display("FAIL fixed_hold: got v=%b ch=%0d want v=1 ch=1", gv_pre, ch_pre); end
    checks++; if (hrq_post !== 1'b0 || gv_post !== 1'b0 || dk_post !== 4'b0000) begin errors++; $display("FAIL fixed_done: got hrq=%b v=%b dack=%b want 0 0 0000", hrq_post, gv_post, dk_post); end
    bus.dreq = '0; bus.mask = '0;
  endtask

  task automatic test_rotating();
    int exp;
    bus.cmd_rotating = 1'b1; bus.dreq = 4'b1111;
    for (int s = 0; s < 5; s++) begin
      bus.mask = '0;
      exp = m_winner(m_eff(bus.dreq, bus.sw_req, bus.mask, 1'b0), 1'b1, m_top);
      grant_cycle(s % 3, ok, gv, ch, dk);
      checks++; if (!ok || gv !== 1'b1 || ch !== CW'(exp)) begin errors++; $display("FAIL rot_grant[%0d]: got ok=%b v=%b ch=%0d want ch=%0d", s, ok, gv, ch, exp); end
      finish_service(2, gv_pre, ch_pre, hrq_post, gv_post, dk_post);
      checks++; if (gv_post !== 1'b0 || ch_pre !== CW'(exp)) begin errors++; $display("FAIL rot_done[%0d]: got v=%b ch=%0d want v=0 ch=%0d", s, gv_post, ch_pre, exp); end
      m_top = (exp + 1) % N;
    end
    bus.dreq = '0; bus.mask = '0;
  endtask

  task automatic test_mask_sw();
    bus.cmd_rotating = 1'b0; bus.mask = 4'b0001; bus.dreq = 4'b0001; bus.sw_req = '0;
    repeat (3) tick();
    checks++; if (bus.hrq !== 1'b0) begin errors++; $display("FAIL masked_hrq: got %b want 0", bus.hrq); end
    bus.sw_req = 4'b0001;
    tick();
    checks++; if (bus.hrq !== 1'b1) begin errors++; $display("FAIL swreq_hrq: got %b want 1", bus.hrq); end
    grant_cycle(0, ok, gv, ch, dk);
    checks++; if (!ok || gv !== 1'b1 || ch !== 2'd0) begin errors++; $display("FAIL swreq_grant: got ok=%b v=%b ch=%0d want ch=0", ok, gv, ch); end
    finish_service(1, gv_pre, ch_pre, hrq_post, gv_post, dk_post);
    bus.dreq = '0; bus.mask = '0; bus.sw_req = '0;
  endtask

  task automatic test_polarity();
    bus.cmd_rotating = 1'b0;
    bus.dreq = 4'b1111; bus.cmd_dreq_low = 1'b1; bus.cmd_dack_low = 1'b1; bus.mask = '0;
    tick(); tick();
    checks++; if (bus.hrq !== 1'b0 || bus.dack !== 4'b1111) begin errors++; $display("FAIL pol_idle: got hrq=%b dack=%b want 0 1111", bus.hrq, bus.dack); end
    bus.dreq = 4'b1011;
    grant_cycle(1, ok, gv, ch, dk);
    checks++; if (!ok || ch !== 2'd2 || dk !== 4'b1011) begin errors++; $display("FAIL pol_grant: got ok=%b ch=%0d dack=%b want ch=2 dack=1011", ok, ch, dk); end
    finish_service(1, gv_pre, ch_pre, hrq_post, gv_post, dk_post);
    checks++; if (dk_post !== 4'b1111) begin errors++; $display("FAIL pol_release: got dack=%b want 1111", dk_post); end
    bus.dreq = '0; bus.cmd_dreq_low = 1'b0; bus.cmd_dack_low = 1'b0; bus.mask = '0;
    tick(); tick();
  endtask

  task automatic test_abort();
    int exp;
    bus.cmd_rotating = 1'b1; bus.mask = '0; bus.dreq = 4'b0100;
    exp = m_winner(m_eff(bus.dreq, bus.sw_req, bus.mask, 1'b0), 1'b1, m_top);
    grant_cycle(0, ok, gv, ch, dk);
    checks++; if (!ok || ch !== CW'(exp)) begin errors++; $display("FAIL abort_setup: got ch=%0d want %0d", ch, exp); end
    finish_service(1, gv_pre, ch_pre, hrq_post, gv_post, dk_post);
    m_top = (exp + 1) % N;
    bus.mask = '0; bus.dreq = 4'b1111;
    exp = m_winner(m_eff(bus.dreq, bus.sw_req, bus.mask, 1'b0), 1'b1, m_top);
    grant_cycle(1, ok, gv, ch, dk);
    checks++; if (!ok || ch !== CW'(exp)) begin errors++; $display("FAIL abort_grant: got ch=%0d want %0d", ch, exp); end
    tick(); tick();
    bus.hlda = 1'b0;
    tick();
    checks++; if (bus.hrq !== 1'b0 || bus.grant_valid !== 1'b0 || bus.dack !== 4'b0000) begin errors++; $display("FAIL abort_clear: got hrq=%b v=%b dack=%b want 0 0 0000", bus.hrq, bus.grant_valid, bus.dack); end
    grant_cycle(0, ok, gv, ch, dk);
    checks++; if (!ok || ch !== CW'(exp)) begin errors++; $display("FAIL abort_top_kept: got ch=%0d want %0d", ch, exp); end
    finish_service(1, gv_pre, ch_pre, hrq_post, gv_post, dk_post);
    m_top = (exp + 1) % N;
    bus.dreq = '0; bus.mask = '0;
  endtask

  task automatic test_reset_mid();
    int exp;
    bus.cmd_rotating = 1'b1; bus.mask = '0; bus.dreq = 4'b1111;
    exp = m_winner(4'b1111, 1'b1, m_top);
    grant_cycle(0, ok, gv, ch, dk);
    finish_service(1, gv_pre, ch_pre, hrq_post, gv_post, dk_post);
    m_top = (exp + 1) % N;
    bus.mask = '0;
    exp = m_winner(4'b1111, 1'b1, m_top);
    grant_cycle(0, ok, gv, ch, dk);
    checks++; if (!ok || ch !== CW'(exp)) begin errors++; $display("FAIL rstmid_grant: got ch=%0d want %0d", ch, exp); end
    tick();
    reset = 1'b1;
    tick();
    checks++; if (bus.hrq !== 1'b0 || bus.grant_valid !== 1'b0 || bus.dack !== 4'b0000) begin errors++; $display("FAIL rstmid_clear: got hrq=%b v=%b dack=%b want 0 0 0000", bus.hrq, bus.grant_valid, bus.dack); end
    reset = 1'b0; bus.hlda = 1'b0; m_top = 0;
    exp = m_winner(4'b1111, 1'b1, m_top);
    grant_cycle(1, ok, gv, ch, dk);
    checks++; if (!ok || ch !== CW'(exp)) begin errors++; $display("FAIL rstmid_top_cleared: got ch=%0d want %0d", ch, exp); end
    finish_service(1, gv_pre, ch_pre, hrq_post, gv_post, dk_post);
    m_top = (exp + 1) % N;
    bus.dreq = '0; bus.mask = '0;
  endtask

  task automatic test_disable();
    bus.cmd_rotating = 1'b0; bus.mask = '0; bus.cmd_disable = 1'b1; bus.dreq = 4'b0010;
    bus.svc_done = 1'b1;
    tick();
    bus.svc_done = 1'b0;
    tick(); tick();
    checks++; if (bus.hrq !== 1'b0 || bus.grant_valid !== 1'b0) begin errors++; $display("FAIL disable_block: got hrq=%b v=%b want 0 0", bus.hrq, bus.grant_valid); end
    bus.cmd_disable = 1'b0;
    tick();
    checks++; if (bus.hrq !== 1'b1) begin errors++; $display("FAIL disable_release: got hrq=%b want 1", bus.hrq); end
    bus.cmd_disable = 1'b1;
    grant_cycle(1, ok, gv, ch, dk);
    checks++; if (!ok || gv !== 1'b1 || ch !== 2'd1) begin errors++; $display("FAIL disable_inflight: got v=%b ch=%0d want v=1 ch=1", gv, ch); end
    finish_service(1, gv_pre, ch_pre, hrq_post, gv_post, dk_post);
    checks++; if (gv_post !== 1'b0 || hrq_post !== 1'b0) begin errors++; $display("FAIL disable_done: got v=%b hrq=%b want 0 0", gv_post, hrq_post); end
    bus.cmd_disable = 1'b0; bus.dreq = '0; bus.mask = '0;
  endtask

  task automatic test_done_with_hlda_drop();
    int exp;
    bus.cmd_rotating = 1'b1; bus.mask = '0; bus.dreq = 4'b1111;
    exp = m_winner(4'b1111, 1'b1, m_top);
    grant_cycle(0, ok, gv, ch, dk);
    checks++; if (!ok || ch !== CW'(exp)) begin errors++; $display("FAIL donedrop_grant: got ch=%0d want %0d", ch, exp); end
    bus.svc_done = 1'b1; bus.hlda = 1'b0;
    tick();
    bus.svc_done = 1'b0;
    checks++; if (bus.hrq !== 1'b0 || bus.grant_valid !== 1'b0) begin errors++; $display("FAIL donedrop_clear: got hrq=%b v=%b want 0 0", bus.hrq, bus.grant_valid); end
    m_top = (exp + 1) % N;
    exp = m_winner(4'b1111, 1'b1, m_top);
    grant_cycle(0, ok, gv, ch, dk);
    checks++; if (!ok || ch !== CW'(exp)) begin errors++; $display("FAIL donedrop_rotated: got ch=%0d want %0d", ch, exp); end
    finish_service(1, gv_pre, ch_pre, hrq_post, gv_post, dk_post);
    m_top = (exp + 1) % N;
    bus.dreq = '0; bus.mask = '0;
  endtask

  task automatic test_random();
    int exp;
    logic [N-1:0] eff, exp_dk;
    logic rot, dl, rl;
    for (int t = 0; t < 24; t++) begin
      rot = 1'($urandom); dl = 1'($urandom); rl = 1'($urandom);
      bus.dreq = N'($urandom); bus.mask = N'($urandom);
      bus.sw_req = ($urandom_range(0, 3) == 0) ? N'($urandom) : '0;
      eff = m_eff(bus.dreq, bus.sw_req, bus.mask, rl);
      if (eff == '0) bus.sw_req[$urandom_range(0, N - 1)] = 1'b1;
      eff = m_eff(bus.dreq, bus.sw_req, bus.mask, rl);
      bus.cmd_rotating = rot; bus.cmd_dreq_low = rl; bus.cmd_dack_low = dl;
      tick();
      exp = m_winner(eff, rot, m_top);
      exp_dk = (4'b0001 << exp) ^ {N{dl}};
      grant_cycle($urandom_range(0, 3), ok, gv, ch, dk);
      checks++; if (!ok || gv !== 1'b1 || ch !== CW'(exp) || dk !== exp_dk) begin errors++; $display("FAIL rand_grant[%0d]: got ok=%b v=%b ch=%0d dack=%b want ch=%0d dack=%b", t, ok, gv, ch, dk, exp, exp_dk); end
      finish_service($urandom_range(0, 4), gv_pre, ch_pre, hrq_post, gv_post, dk_post);
      checks++; if (gv_pre !== 1'b1 || ch_pre !== CW'(exp)) begin errors++; $display("FAIL rand_hold[%0d]: got v=%b ch=%0d want v=1 ch=%0d", t, gv_pre, ch_pre, exp); end
      checks++; if (hrq_post !== 1'b0 || gv_post !== 1'b0 || dk_post !== {N{dl}}) begin errors++; $display("FAIL rand_done[%0d]: got hrq=%b v=%b dack=%b want 0 0 %b", t, hrq_post, gv_post, dk_post, {N{dl}}); end
      if (rot) m_top = (exp + 1) % N;
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    bus.dreq = '0; bus.sw_req = '0; bus.mask = '0;
    bus.cmd_disable = 1'b0; bus.cmd_rotating = 1'b0;
    bus.cmd_dreq_low = 1'b0; bus.cmd_dack_low = 1'b0;
    bus.hlda = 1'b0; bus.svc_done = 1'b0;
    test_reset();
    test_fixed();
    test_rotating();
    test_mask_sw();
    test_polarity();
    test_abort();
    test_reset_mid();
    test_disable();
    test_done_with_hlda_drop();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
